// File: rtl/conv_mac_accum_pkg.sv
// Shared widths, fixed-point constants and state encoding for the convolution MAC stage.
// align_bias turns a Q8.8 bias into the Q16.16 accumulator preload.
package conv_mac_accum_pkg;

  localparam int DATA_BITS     = 16;
  localparam int INTERNAL_BITS = 32;
  localparam int FRAC_BITS     = 8;
  localparam logic [INTERNAL_BITS-1:0] ROUND_CONST = 32'h0000_0080;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Sign-extend then shift; the optional 0x80 makes a later [23:8] slice round half-up.
  function automatic logic [INTERNAL_BITS-1:0] align_bias(
    input logic [DATA_BITS-1:0] b,
    input logic                 round_en
  );
    logic [INTERNAL_BITS-1:0] ext;
    ext = {{(INTERNAL_BITS-DATA_BITS){b[DATA_BITS-1]}}, b};
    return (ext << FRAC_BITS) + (round_en ? ROUND_CONST : '0);
  endfunction

endpackage

// File: rtl/conv_mac_accum_mul.sv
// Registered signed multiplier: one cycle from operands to full-width product,
// with the operand valid carried alongside.
module conv_mul
  import conv_mac_accum_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic signed [DATA_BITS-1:0]   a,
  input  logic signed [DATA_BITS-1:0]   b,
  output logic signed [2*DATA_BITS-1:0] prod,
  output logic                          prod_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= in_valid;
      if (in_valid) prod <= a * b;
    end
  end

endmodule

// File: rtl/conv_mac_accum.sv
// One convolution output: TAPS Q8.8 products summed in Q16.16 on top of an aligned bias,
// optional ReLU, presented on a held valid/ready output.
module conv_mac_accum
  import conv_mac_accum_pkg::*;
#(
  parameter int TAPS     = 9,
  parameter bit ROUND_EN = 1'b1,
  parameter bit RELU_EN  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DATA_BITS-1:0]     bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BITS-1:0]     in_data,
  input  logic [DATA_BITS-1:0]     in_weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INTERNAL_BITS-1:0] out_data,
  output logic                     busy,
  output state_t                   state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and out_valid/out_data hold until the transfer.

  state_t                   state, state_next;
  logic [7:0]               cnt;
  logic [INTERNAL_BITS-1:0] acc;
  logic signed [2*DATA_BITS-1:0] prod;
  logic                     pv;
  logic                     fire;
  logic                     last_fire;

  assign in_ready  = (state == S_ACC);
  assign fire      = in_valid && in_ready;
  assign last_fire = fire && (cnt == 8'(TAPS - 1));
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  conv_mul u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (fire),
    .a          (in_data),
    .b          (in_weight),
    .prod       (prod),
    .prod_valid (pv)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_ACC;
      S_ACC:   if (last_fire) state_next = S_DRAIN;
      S_DRAIN: state_next = S_OUT;
      S_OUT:   if (out_valid && out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        acc <= align_bias(bias, ROUND_EN);
        cnt <= '0;
      end else begin
        if (pv)   acc <= acc + INTERNAL_BITS'(prod);
        if (fire) cnt <= cnt + 8'd1;
      end
    end
  end

  // The first OUT cycle registers the finished sum, so the result port is a clean flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (state == S_OUT) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= (RELU_EN && acc[INTERNAL_BITS-1]) ? '0 : acc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
